// File: rtl/detector_rr_scheduler.sv
// detector_rr_scheduler
// Shares one 4-bit-input Moore pattern detector between NREQ requesters.
// Ownership rotates round-robin. A grant lasts at most BURST nibbles.
// The detector is cleared before every new owner, and each detector hit
// is routed back to the requester whose nibble caused it.
//
// Ports
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   req_i        : per-requester "nibble valid on my lane"
//   data_i       : packed nibbles, requester k on [4k+3:4k]
//   take_o       : one-hot, the owner's nibble is consumed this cycle
//   gnt_o        : one-hot current owner, zero when idle
//   busy_o       : scheduler is not idle
//   det_data_o   : nibble to the detector (zero when nothing is taken)
//   det_clr_o    : one-cycle synchronous clear pulse to the detector
//   det_hit_i    : Moore output of the detector (reflects previous nibble)
//   hit_o        : one-hot registered hit pulse to the originating requester
module detector_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_i,
  input  logic [4*NREQ-1:0] data_i,
  output logic [NREQ-1:0]   take_o,
  output logic [NREQ-1:0]   gnt_o,
  output logic              busy_o,
  output logic [3:0]        det_data_o,
  output logic              det_clr_o,
  input  logic              det_hit_i,
  output logic [NREQ-1:0]   hit_o
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CLEAR  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  localparam logic [3:0]    LAST_BEAT = 4'(BURST - 1);
  localparam logic [OW-1:0] LAST_REQ  = OW'(NREQ - 1);

  function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = {NREQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  // The owner register doubles as the round-robin pointer: the current
  // owner is always the most recent winner.
  logic [OW-1:0]   owner_r;
  logic [3:0]      cnt_r;
  logic            vld_d_r;
  logic [OW-1:0]   own_d_r;
  logic [NREQ-1:0] hit_r;

  logic            win_found_s;
  logic [OW-1:0]   win_idx_s;
  logic [1:0]      arb_next_s;
  logic            grant_s;
  logic [NREQ-1:0] take_s;
  logic [3:0]      data_s;
  logic [3:0]      owner_lane_s;

  // Round-robin search starting just after the last owner and wrapping,
  // so the previous owner is considered last.
  always_comb begin
    int j;
    j           = 0;
    win_found_s = 1'b0;
    win_idx_s   = owner_r;
    for (int i = 1; i <= NREQ; i++) begin
      j = int'(owner_r) + i;
      if (j >= NREQ) begin
        j = j - NREQ;
      end else begin
        j = j;
      end
      if (!win_found_s && req_i[OW'(j)]) begin
        win_found_s = 1'b1;
        win_idx_s   = OW'(j);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  assign arb_next_s   = win_found_s ? S_CLEAR : S_IDLE;
  assign owner_lane_s = data_i[{owner_r, 2'b00} +: 4];

  // Next-state, take and detector-data decode.
  always_comb begin
    state_nxt_s = state_r;
    take_s      = {NREQ{1'b0}};
    data_s      = 4'h0;
    grant_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        state_nxt_s = arb_next_s;
        grant_s     = win_found_s;
      end
      S_CLEAR: begin
        state_nxt_s = S_STREAM;
      end
      S_STREAM: begin
        if (req_i[owner_r]) begin
          take_s = onehot(owner_r);
          data_s = owner_lane_s;
          if (cnt_r == LAST_BEAT) begin
            state_nxt_s = S_DRAIN;
          end else begin
            state_nxt_s = S_STREAM;
          end
        end else begin
          // Owner went quiet: this cycle acts as the drain, so re-arbitrate now.
          state_nxt_s = arb_next_s;
          grant_s     = win_found_s;
        end
      end
      S_DRAIN: begin
        state_nxt_s = arb_next_s;
        grant_s     = win_found_s;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, owner, burst counter and hit-attribution pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      owner_r <= LAST_REQ;
      cnt_r   <= 4'd0;
      vld_d_r <= 1'b0;
      own_d_r <= {OW{1'b0}};
      hit_r   <= {NREQ{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        owner_r <= win_idx_s;
      end
      if (state_r == S_CLEAR) begin
        cnt_r <= 4'd0;
      end else if (|take_s) begin
        cnt_r <= cnt_r + 4'd1;
      end
      vld_d_r <= |take_s;
      own_d_r <= owner_r;
      // Hit belongs to whoever owned the nibble taken two edges ago,
      // independent of the current grant.
      hit_r   <= (vld_d_r && det_hit_i) ? onehot(own_d_r) : {NREQ{1'b0}};
    end
  end

  assign take_o     = take_s;
  assign det_data_o = data_s;
  assign det_clr_o  = (state_r == S_CLEAR);
  assign busy_o     = (state_r != S_IDLE);
  assign gnt_o      = (state_r != S_IDLE) ? onehot(owner_r) : {NREQ{1'b0}};
  assign hit_o      = hit_r;

endmodule
